// File: rtl/dpro_acc_stage.sv
`default_nettype none
// ============================================================================
// Module   : dpro_acc_stage
// Purpose  : Result stage behind the ALU. Registers ordinary ALU results and
//            forwards them to writeback over valid/ready. For DPRO beats it
//            accumulates a programmable number of element products and emits
//            one dot-product sum per vector.
// Ports    : clk, rst_n         - clock, synchronous active-low reset
//            in_valid/in_ready  - ALU beat handshake
//            op_code, alu_result, vec_len - beat payload
//            wb_valid/wb_ready  - writeback handshake
//            wb_data, wb_op     - emitted result and its opcode
//            acc_ovf            - signed overflow seen in current/last DPRO sum
//            seq_err            - sticky, DPRO vector aborted by non-DPRO beat
//            busy               - accumulating a vector
// Revision : 1.0 - initial release
// ============================================================================
module dpro_acc_stage #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op_code,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [LEN_W-1:0]  vec_len,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [OP_W-1:0]   wb_op,
    output logic              acc_ovf,
    output logic              seq_err,
    output logic              busy
);

    localparam logic [OP_W-1:0] C_OP_ADD  = OP_W'(3'b000);
    localparam logic [OP_W-1:0] C_OP_MUL  = OP_W'(3'b001);
    localparam logic [OP_W-1:0] C_OP_LDR  = OP_W'(3'b100);
    localparam logic [OP_W-1:0] C_OP_STR  = OP_W'(3'b101);
    localparam logic [OP_W-1:0] C_OP_MOV  = OP_W'(3'b110);
    localparam logic [OP_W-1:0] C_OP_DPRO = OP_W'(3'b111);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [OP_W-1:0]     wb_op_q, wb_op_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                acc_ovf_q, acc_ovf_d;
    logic                seq_err_q, seq_err_d;

    logic                w_accept;
    logic                w_is_dpro;
    logic                w_is_pass;
    logic [DATA_W-1:0]   w_sum;
    logic                w_sum_ovf;
    logic [LEN_W-1:0]    w_len;

    // Single output register: a new beat fits whenever the register is empty
    // or is being drained in the same cycle.
    assign in_ready = !wb_valid_q || wb_ready;
    assign w_accept = in_valid && in_ready;

    assign w_is_dpro = (op_code == C_OP_DPRO);
    always_comb begin
        w_is_pass = 1'b0;
        case (op_code)
            C_OP_ADD, C_OP_MUL, C_OP_LDR, C_OP_STR, C_OP_MOV: w_is_pass = 1'b1;
            default:                                          w_is_pass = 1'b0;
        endcase
    end

    // Two's-complement wrap; overflow when operands agree in sign but the
    // result does not.
    assign w_sum     = acc_q + alu_result;
    assign w_sum_ovf = (acc_q[DATA_W-1] == alu_result[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != acc_q[DATA_W-1]);

    // A zero length is treated as a single-element vector.
    assign w_len = (vec_len == '0) ? LEN_W'(1) : vec_len;

    always_comb begin
        logic idle_path;

        state_d    = state_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_op_d    = wb_op_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        acc_ovf_d  = acc_ovf_q;
        seq_err_d  = seq_err_q;
        idle_path  = 1'b0;

        if (wb_valid_q && wb_ready) begin
            wb_valid_d = 1'b0;
        end

        if (w_accept) begin
            if (state_q == S_ACCUM) begin
                if (w_is_dpro) begin
                    acc_d     = w_sum;
                    cnt_d     = cnt_q - LEN_W'(1);
                    acc_ovf_d = acc_ovf_q || w_sum_ovf;
                    if (cnt_q == LEN_W'(1)) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = w_sum;
                        wb_op_d    = C_OP_DPRO;
                        state_d    = S_IDLE;
                    end
                end else begin
                    // Abort the vector; the interrupting beat is then
                    // handled exactly as it would be from IDLE.
                    seq_err_d = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                    idle_path = 1'b1;
                end
            end else begin
                idle_path = 1'b1;
            end

            if (idle_path) begin
                if (w_is_pass) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = alu_result;
                    wb_op_d    = op_code;
                end else if (w_is_dpro) begin
                    acc_ovf_d = 1'b0;
                    if (w_len == LEN_W'(1)) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_result;
                        wb_op_d    = C_OP_DPRO;
                    end else begin
                        acc_d   = alu_result;
                        cnt_d   = w_len - LEN_W'(1);
                        state_d = S_ACCUM;
                    end
                end
                // Undefined opcodes fall through: accepted and dropped.
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_op_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            acc_ovf_q  <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_op_q    <= wb_op_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            acc_ovf_q  <= acc_ovf_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_op    = wb_op_q;
    assign acc_ovf  = acc_ovf_q;
    assign seq_err  = seq_err_q;
    assign busy     = (state_q == S_ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_dpro_acc_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpro_acc_stage
// Purpose  : Directed self-checking bench for dpro_acc_stage. A transaction
//            level model computes expected writeback results; a negedge
//            process compares every cycle, and directed steps pin literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpro_acc_stage;

    localparam longint C_MAXP = 64'sd2147483647;
    localparam longint C_MINN = -64'sd2147483648;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op_code;
    logic [31:0] alu_result;
    logic [7:0]  vec_len;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [2:0]  wb_op;
    logic        acc_ovf;
    logic        seq_err;
    logic        busy;

    dpro_acc_stage #(.DATA_W(32), .OP_W(3), .LEN_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_code    (op_code),
        .alu_result (alu_result),
        .vec_len    (vec_len),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_op      (wb_op),
        .acc_ovf    (acc_ovf),
        .seq_err    (seq_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  op;
        logic        ovf;
    } exp_t;

    exp_t   exp_q[$];
    bit     m_busy = 0;
    bit     m_ovf  = 0;
    bit     m_seq  = 0;
    int     m_cnt  = 0;
    longint m_acc  = 0;

    int          n_out = 0;
    logic [31:0] last_data = '0;
    logic [2:0]  last_op   = '0;
    logic        last_ovf  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one call per accepted beat.
    task automatic model_accept(input logic [2:0] op, input logic [31:0] x, input logic [7:0] len);
        bit     handle_as_idle;
        longint s;
        int     n;
        handle_as_idle = 1;
        if (m_busy) begin
            if (op == 3'b111) begin
                s = m_acc + longint'($signed(x));
                if (s > C_MAXP || s < C_MINN) m_ovf = 1;
                m_acc = longint'($signed(s[31:0]));
                m_cnt--;
                if (m_cnt == 0) begin
                    exp_q.push_back(exp_t'{s[31:0], 3'b111, m_ovf});
                    m_busy = 0;
                end
                handle_as_idle = 0;
            end else begin
                m_seq  = 1;
                m_busy = 0;
            end
        end
        if (handle_as_idle) begin
            if (op inside {3'b000, 3'b001, 3'b100, 3'b101, 3'b110}) begin
                exp_q.push_back(exp_t'{x, op, m_ovf});
            end else if (op == 3'b111) begin
                n     = (len == 8'd0) ? 1 : int'(len);
                m_ovf = 0;
                if (n == 1) begin
                    exp_q.push_back(exp_t'{x, 3'b111, 1'b0});
                end else begin
                    m_busy = 1;
                    m_acc  = longint'($signed(x));
                    m_cnt  = n - 1;
                end
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_busy = 0;
        m_ovf  = 0;
        m_seq  = 0;
        m_cnt  = 0;
        m_acc  = 0;
    endtask

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        chk("in_ready", {63'd0, in_ready}, {63'd0, (exp_q.size() == 0) || wb_ready});
        chk("wb_valid", {63'd0, wb_valid}, {63'd0, exp_q.size() != 0});
        chk("busy",     {63'd0, busy},     {63'd0, m_busy});
        chk("seq_err",  {63'd0, seq_err},  {63'd0, m_seq});
        chk("acc_ovf",  {63'd0, acc_ovf},  {63'd0, m_ovf});
        if (wb_valid && wb_ready && exp_q.size() != 0) begin
            chk("xfer_data", {32'd0, wb_data}, {32'd0, exp_q[0].d});
            chk("xfer_op",   {61'd0, wb_op},   {61'd0, exp_q[0].op});
            chk("xfer_ovf",  {63'd0, acc_ovf}, {63'd0, exp_q[0].ovf});
            last_data = wb_data;
            last_op   = wb_op;
            last_ovf  = acc_ovf;
            n_out++;
            void'(exp_q.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [2:0] op, input logic [31:0] x, input logic [7:0] len);
        bit taken;
        int waits;
        taken      = 0;
        waits      = 0;
        in_valid   = 1'b1;
        op_code    = op;
        alu_result = x;
        vec_len    = len;
        while (!taken) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            if (taken) model_accept(op, x, len);
            #1;
            if (!taken) begin
                waits++;
                if (waits > 20) begin
                    chk("beat_timeout", 64'd1, 64'd0);
                    break;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd0);
        chk({tag, "_wb_data"},  {32'd0, wb_data},  64'd0);
        chk({tag, "_wb_op"},    {61'd0, wb_op},    64'd0);
        chk({tag, "_acc_ovf"},  {63'd0, acc_ovf},  64'd0);
        chk({tag, "_seq_err"},  {63'd0, seq_err},  64'd0);
        chk({tag, "_busy"},     {63'd0, busy},     64'd0);
    endtask

    initial begin
        int n0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        op_code    = 3'b000;
        alu_result = '0;
        vec_len    = '0;
        wb_ready   = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_reset_state("reset");
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // ADD pass-through, latency 1.
        n0 = n_out;
        beat(3'b000, 32'h0000_0007, 8'd0);
        chk("add_valid_next", {63'd0, wb_valid}, 64'd1);
        chk("add_data_next",  {32'd0, wb_data},  64'd7);
        idle(2);
        chk("add_data", {32'd0, last_data}, 64'd7);
        chk("add_op",   {61'd0, last_op},   64'd0);
        chk("add_cnt",  n_out, n0 + 1);

        // Undefined opcode is dropped.
        n0 = n_out;
        beat(3'b010, 32'd123, 8'd0);
        idle(2);
        chk("undef_dropped", n_out, n0);

        // MOV held under backpressure for 3 cycles.
        wb_ready = 1'b0;
        n0 = n_out;
        beat(3'b110, 32'h0000_0055, 8'd0);
        repeat (3) begin
            idle(1);
            chk("mov_in_ready", {63'd0, in_ready}, 64'd0);
            chk("mov_hold_data", {32'd0, wb_data}, 64'h55);
            chk("mov_hold_op",   {61'd0, wb_op},   64'd6);
        end
        chk("mov_no_xfer", n_out, n0);
        wb_ready = 1'b1;
        idle(3);
        chk("mov_single_xfer", n_out, n0 + 1);
        chk("mov_data", {32'd0, last_data}, 64'h55);

        // Dot product of 3,-5,10,2 with a gap.
        n0 = n_out;
        beat(3'b111, 32'd3, 8'd4);
        beat(3'b111, 32'hFFFF_FFFB, 8'd9);
        idle(1);
        beat(3'b111, 32'd10, 8'd0);
        idle(1);
        chk("dp_busy", {63'd0, busy}, 64'd1);
        chk("dp_no_early_out", n_out, n0);
        beat(3'b111, 32'd2, 8'd0);
        idle(2);
        chk("dp_count", n_out, n0 + 1);
        chk("dp_data",  {32'd0, last_data}, 64'd10);
        chk("dp_op",    {61'd0, last_op},   64'd7);
        chk("dp_ovf",   {63'd0, last_ovf},  64'd0);

        // Overflow, then a clean vector clears the flag.
        beat(3'b111, 32'h7FFF_FFFF, 8'd2);
        beat(3'b111, 32'h0000_0001, 8'd0);
        idle(2);
        chk("ovf_data", {32'd0, last_data}, 64'h8000_0000);
        chk("ovf_flag", {63'd0, last_ovf},  64'd1);
        beat(3'b111, 32'd1, 8'd2);
        beat(3'b111, 32'd1, 8'd0);
        idle(2);
        chk("clean_data", {32'd0, last_data}, 64'd2);
        chk("clean_ovf",  {63'd0, last_ovf},  64'd0);

        // Abort by MUL.
        n0 = n_out;
        beat(3'b111, 32'd5, 8'd3);
        beat(3'b001, 32'd9, 8'd0);
        idle(2);
        chk("abort_seq_err", {63'd0, seq_err}, 64'd1);
        chk("abort_busy",    {63'd0, busy},    64'd0);
        chk("abort_count",   n_out, n0 + 1);
        chk("abort_data",    {32'd0, last_data}, 64'd9);
        chk("abort_op",      {61'd0, last_op},   64'd1);

        // vec_len=0 is a single-element vector.
        n0 = n_out;
        beat(3'b111, 32'd6, 8'd0);
        idle(2);
        chk("len0_count", n_out, n0 + 1);
        chk("len0_data",  {32'd0, last_data}, 64'd6);
        chk("len0_op",    {61'd0, last_op},   64'd7);

        // Reset mid-vector, then a fresh vector.
        beat(3'b111, 32'd1, 8'd5);
        beat(3'b111, 32'd2, 8'd0);
        chk("mid_busy", {63'd0, busy}, 64'd1);
        do_reset();
        chk_reset_state("midrst");
        n0 = n_out;
        beat(3'b111, 32'd4, 8'd2);
        beat(3'b111, 32'd5, 8'd0);
        idle(2);
        chk("fresh_count", n_out, n0 + 1);
        chk("fresh_data",  {32'd0, last_data}, 64'd9);

        // Back-to-back ADD beats.
        n0 = n_out;
        for (int i = 0; i < 6; i++) begin
            beat(3'b000, 32'd100 + 32'(i), 8'd0);
        end
        idle(2);
        chk("b2b_count", n_out, n0 + 6);
        chk("b2b_last",  {32'd0, last_data}, 64'd105);

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dpro_acc_stage.md
Name: dpro_acc_stage

Overview:
- Result stage directly downstream of the ALU.
- Registers each ALU result and forwards it to writeback over a valid/ready handshake.
- For DPRO (3'b111) the ALU produces one element product per beat; this block sums a programmable number of products and emits one dot-product result per vector.
- Sits between the ALU output and the register-file/memory writeback port.

Parameters:
- DATA_W, 32, ALU result and writeback data width
- OP_W, 3, opcode width
- LEN_W, 8, vector-length field width (max 2^LEN_W-1 elements)

Ports:
- clk  input  1  clock, all state changes on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  ALU result beat valid
- in_ready  output  1  stage can accept a beat this cycle
- op_code  input  OP_W  opcode accompanying the beat (ADD=000, MUL=001, LDR=100, STR=101, MOV=110, DPRO=111)
- alu_result  input  DATA_W  signed ALU output
- vec_len  input  LEN_W  DPRO element count; sampled only on the first DPRO beat of a vector
- wb_valid  output  1  writeback beat valid
- wb_ready  input  1  writeback consumer accepts beat
- wb_data  output  DATA_W  result or dot-product sum
- wb_op  output  OP_W  opcode of the emitted result
- acc_ovf  output  1  sticky: signed overflow occurred in the current/last emitted DPRO sum
- seq_err  output  1  sticky: DPRO vector aborted by a non-DPRO beat; cleared only by reset
- busy  output  1  high while in ACCUM

Behaviour:
- Reset (rst_n=0 at posedge) values:
  - state=IDLE; wb_valid=0; wb_data=0; wb_op=0
  - acc=0; cnt=0; acc_ovf=0; seq_err=0; busy=0
  - Reset mid-vector discards the partial sum.
- Handshake:
  - Beat accepted when in_valid & in_ready.
  - Output transfer when wb_valid & wb_ready.
  - in_ready = !wb_valid | wb_ready (single output register, full throughput).
  - While wb_valid=1 and wb_ready=0: wb_data, wb_op, acc_ovf stay stable.
- States: IDLE, ACCUM.
- IDLE:
  - Accepted ADD/MUL/LDR/STR/MOV: wb_data<=alu_result, wb_op<=op_code, wb_valid<=1 next cycle (latency 1).
  - Accepted DPRO:
    - len = (vec_len==0) ? 1 : vec_len.
    - If len==1: emit alu_result immediately as a pass-through with wb_op=DPRO and acc_ovf<=0; stay in IDLE.
    - Else: acc<=alu_result, cnt<=len-1, acc_ovf<=0, go to ACCUM.
  - Undefined opcodes (010, 011): accepted and dropped; no output, no state change.
- ACCUM:
  - Accepted DPRO beat: sum = acc + alu_result, DATA_W-bit two's-complement wrap.
  - acc_ovf set if both operands have the same sign and the sum's sign differs.
  - cnt decrements per beat. On the beat where cnt==1: wb_data<=sum, wb_op<=DPRO, wb_valid<=1, state<=IDLE.
  - Total latency from the last element beat to wb_valid is 1 cycle.
  - Accepted non-DPRO beat: vector aborted, acc discarded, seq_err<=1, state<=IDLE. The non-DPRO beat is processed exactly as in IDLE in the same cycle.
  - in_valid=0 gaps: state held indefinitely.
- vec_len is ignored on every beat except the first of a vector.
- wb_valid clears after transfer unless a new result is loaded in the same cycle (back-to-back).

Test Plan:
- Pass-through:
  - ADD beat alu_result=0x0000_0007, wb_ready=1 -> next cycle wb_valid=1, wb_data=7, wb_op=000.
  - MOV beat with wb_ready=0 for 3 cycles -> in_ready=0, wb_data held, then a single transfer.
- Dot product:
  - vec_len=4, DPRO beats 3,-5,10,2 with one idle gap -> exactly one output: wb_data=10, wb_op=111, acc_ovf=0.
  - No output is produced before the 4th beat.
- Overflow:
  - vec_len=2, beats 0x7FFF_FFFF, 0x0000_0001 -> wb_data=0x8000_0000, acc_ovf=1.
  - Next vector of len 2 with beats 1,1 -> wb_data=2, acc_ovf=0.
- Abort:
  - vec_len=3, DPRO 5, then MUL beat 9 -> seq_err=1, single output wb_data=9, wb_op=001, busy=0.
- Length edge cases and reset:
  - vec_len=0 with DPRO beat 6 -> immediate output 6.
  - rst_n=0 asserted in ACCUM after 2 of 5 beats -> next cycle all outputs at reset values.
  - A subsequent fresh vector sums correctly.
- Back-to-back throughput:
  - Continuous ADD beats with wb_ready=1 -> one output per cycle, in_ready held high.
